// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: constants shared by the pipeline hazard controller.
//   - MD_LATENCY_DEFAULT : default busy time of the multiply/divide unit
//   - ST_RUN / ST_MD_BUSY: MD busy-timer FSM state encoding
//   - pipe_ctrl_t        : bundle of the four pipeline control strobes
package hazard_ctrl_pkg;

   localparam int unsigned MD_LATENCY_DEFAULT = 8;

   // Wide enough for MD_LATENCY-1 up to 14.
   localparam int unsigned MD_CNT_W = 4;

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_MD_BUSY = 1'b1;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic idex_bubble;
      logic ifid_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         idex_bubble: 1'b0, ifid_flush: 1'b0};
   localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0,
                                         idex_bubble: 1'b1, ifid_flush: 1'b0};
   localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         idex_bubble: 1'b1, ifid_flush: 1'b1};

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: tracks how long the multiply/divide unit stays busy.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   start_i : mult/div in EX issues this cycle (ignored while busy)
//   busy_o  : high for MD_LATENCY cycles starting the cycle after start_i
//   done_o  : one-cycle pulse on the last busy cycle
module md_busy_timer
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   output logic busy_o,
   output logic done_o
);

   logic [0:0]          state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (start_i) begin
               cnt_d   = MD_CNT_W'(MD_LATENCY - 1);
               state_d = ST_MD_BUSY;
            end
         end
         ST_MD_BUSY: begin
            // A start seen here belongs to an overlapping issue and is dropped.
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - MD_CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q == ST_MD_BUSY);
   assign done_o = busy_o && (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detection and stall/flush control.
//   clk, rst                : clock, asynchronous active-high reset
//   RsAddr_id, RtAddr_id    : source registers of the instruction in ID
//   MemRead_ex, RegWriteAddr_ex : EX holds a load and its destination
//   Branch_taken_ex         : branch/jump resolved taken in EX
//   MD_start_ex             : mult/div in EX issues this cycle
//   MDRead_id, MD_start_id  : ID holds mfhi/mflo, or a mult/div
//   PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush : pipeline control
//   MD_busy, MD_done        : mult/div unit busy / completion pulse
//   StallCnt                : saturating count of cycles with PCWrite low
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  RsAddr_id,
   input  logic [4:0]  RtAddr_id,
   input  logic        MemRead_ex,
   input  logic [4:0]  RegWriteAddr_ex,
   input  logic        Branch_taken_ex,
   input  logic        MD_start_ex,
   input  logic        MDRead_id,
   input  logic        MD_start_id,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IDEX_Bubble,
   output logic        IFID_Flush,
   output logic        MD_busy,
   output logic        MD_done,
   output logic [15:0] StallCnt
);

   logic       load_use;
   logic       md_stall;
   pipe_ctrl_t ctrl;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   md_busy_timer #(
      .MD_LATENCY(MD_LATENCY)
   ) u_md_busy_timer (
      .clk_i  (clk),
      .rst_i  (rst),
      .start_i(MD_start_ex),
      .busy_o (MD_busy),
      .done_o (MD_done)
   );

   // $0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                     ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));

   // HI/LO are valid on the done cycle, so mfhi/mflo may proceed then.
   assign md_stall = MD_busy && (MD_start_id || (MDRead_id && !MD_done));

   always_comb begin
      if (rst) begin
         ctrl = CTRL_RUN;
      end else if (Branch_taken_ex) begin
         // Flush wins: the stalled ID instruction is on the wrong path anyway.
         ctrl = CTRL_FLUSH;
      end else if (load_use || md_stall) begin
         ctrl = CTRL_STALL;
      end else begin
         ctrl = CTRL_RUN;
      end
   end

   assign PCWrite     = ctrl.pc_write;
   assign IFIDWrite   = ctrl.ifid_write;
   assign IDEX_Bubble = ctrl.idex_bubble;
   assign IFID_Flush  = ctrl.ifid_flush;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!ctrl.pc_write && (stall_cnt_q != STALL_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int unsigned LAT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  RsAddr_id, RtAddr_id, RegWriteAddr_ex;
   logic        MemRead_ex, Branch_taken_ex, MD_start_ex, MDRead_id, MD_start_id;
   logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, MD_busy, MD_done;
   logic [15:0] StallCnt;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MD_LATENCY(LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .RsAddr_id      (RsAddr_id),
      .RtAddr_id      (RtAddr_id),
      .MemRead_ex     (MemRead_ex),
      .RegWriteAddr_ex(RegWriteAddr_ex),
      .Branch_taken_ex(Branch_taken_ex),
      .MD_start_ex    (MD_start_ex),
      .MDRead_id      (MDRead_id),
      .MD_start_id    (MD_start_id),
      .PCWrite        (PCWrite),
      .IFIDWrite      (IFIDWrite),
      .IDEX_Bubble    (IDEX_Bubble),
      .IFID_Flush     (IFID_Flush),
      .MD_busy        (MD_busy),
      .MD_done        (MD_done),
      .StallCnt       (StallCnt)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: cycles of MD busy time still to come, and stall total.
   int m_rem   = 0;
   int m_stall = 0;

   logic        s_pc, s_ifid, s_bub, s_fl, s_busy, s_done;
   logic [15:0] s_cnt;

   typedef struct {
      string      name;
      logic       mem_rd;
      logic [4:0] wa;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       br;
      logic [3:0] exp;  // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush}
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      RsAddr_id       = 5'd0;
      RtAddr_id       = 5'd0;
      MemRead_ex      = 1'b0;
      RegWriteAddr_ex = 5'd0;
      Branch_taken_ex = 1'b0;
      MD_start_ex     = 1'b0;
      MDRead_id       = 1'b0;
      MD_start_id     = 1'b0;
   endtask

   // Sample at the falling edge, compare with the model, then advance the
   // model across the next rising edge. Returns at posedge+1.
   task automatic cycle();
      bit       e_busy, e_done, lu, mdst;
      bit [3:0] e;
      @(negedge clk);
      if (rst) begin
         m_rem   = 0;
         m_stall = 0;
      end
      e_busy = (m_rem > 0);
      e_done = (m_rem == 1);
      lu   = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
             ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));
      mdst = e_busy && (MD_start_id || (MDRead_id && !e_done));
      if (rst)                  e = 4'b1100;
      else if (Branch_taken_ex) e = 4'b1111;
      else if (lu || mdst)      e = 4'b0010;
      else                      e = 4'b1100;
      s_pc   = PCWrite;
      s_ifid = IFIDWrite;
      s_bub  = IDEX_Bubble;
      s_fl   = IFID_Flush;
      s_busy = MD_busy;
      s_done = MD_done;
      s_cnt  = StallCnt;
      chk("model_pc_write", s_pc, e[3]);
      chk("model_ifid_write", s_ifid, e[2]);
      chk("model_idex_bubble", s_bub, e[1]);
      chk("model_ifid_flush", s_fl, e[0]);
      chk("model_md_busy", s_busy, e_busy);
      chk("model_md_done", s_done, e_done);
      chk("model_stall_cnt", s_cnt, m_stall);
      if (!rst) begin
         if (!e[3] && m_stall < 65535) m_stall++;
         if (m_rem > 0) m_rem--;
         else if (MD_start_ex) m_rem = LAT;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"mem_rd_off",   1'b0, 5'd5,  5'd5, 5'd0,  1'b0, 4'b1100};
      vecs[1] = '{"load_use_rs",  1'b1, 5'd5,  5'd5, 5'd1,  1'b0, 4'b0010};
      vecs[2] = '{"load_use_rt",  1'b1, 5'd7,  5'd1, 5'd7,  1'b0, 4'b0010};
      vecs[3] = '{"zero_reg",     1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 4'b1100};
      vecs[4] = '{"no_match",     1'b1, 5'd3,  5'd4, 5'd6,  1'b0, 4'b1100};
      vecs[5] = '{"branch_only",  1'b0, 5'd0,  5'd2, 5'd3,  1'b1, 4'b1111};
      vecs[6] = '{"branch_lu",    1'b1, 5'd5,  5'd5, 5'd0,  1'b1, 4'b1111};
      vecs[7] = '{"load_use_r31", 1'b1, 5'd31, 5'd2, 5'd31, 1'b0, 4'b0010};

      // Reset with hazards and a flush on the inputs: outputs stay at run values.
      idle();
      rst             = 1'b1;
      MemRead_ex      = 1'b1;
      RegWriteAddr_ex = 5'd5;
      RsAddr_id       = 5'd5;
      Branch_taken_ex = 1'b1;
      MD_start_ex     = 1'b1;
      cycle();
      chk("rst_pc_write", s_pc, 1);
      chk("rst_flush", s_fl, 0);
      chk("rst_bubble", s_bub, 0);
      chk("rst_md_busy", s_busy, 0);
      chk("rst_stall_cnt", s_cnt, 0);
      idle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("post_rst_md_busy", s_busy, 0);

      // Combinational hazard table.
      for (int i = 0; i < 8; i++) begin
         idle();
         MemRead_ex      = vecs[i].mem_rd;
         RegWriteAddr_ex = vecs[i].wa;
         RsAddr_id       = vecs[i].rs;
         RtAddr_id       = vecs[i].rt;
         Branch_taken_ex = vecs[i].br;
         cycle();
         chk({"vec_", vecs[i].name}, {s_pc, s_ifid, s_bub, s_fl}, vecs[i].exp);
      end

      // Single load-use stall.
      idle();
      reset_dut();
      MemRead_ex      = 1'b1;
      RegWriteAddr_ex = 5'd5;
      RsAddr_id       = 5'd5;
      cycle();
      chk("lw_stall_pc", s_pc, 0);
      chk("lw_stall_bubble", s_bub, 1);
      chk("lw_cnt_before", s_cnt, 0);
      idle();
      cycle();
      chk("lw_release_pc", s_pc, 1);
      chk("lw_cnt_after", s_cnt, 1);

      // MD issue at cycle 10 with mfhi waiting in ID.
      reset_dut();
      repeat (9) cycle();
      MD_start_ex = 1'b1;
      MDRead_id   = 1'b1;
      cycle();
      chk("md_k0_busy", s_busy, 0);
      chk("md_k0_pc", s_pc, 1);
      MD_start_ex = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         chk("md_seq_busy", s_busy, (k <= 8));
         chk("md_seq_done", s_done, (k == 8));
         chk("md_seq_pc", s_pc, (k >= 8));
      end
      chk("md_seq_stall_cnt", s_cnt, 7);

      // Overlapping start is ignored; a branch does not abort the MD operation.
      idle();
      MD_start_ex = 1'b1;
      cycle();
      for (int k = 1; k <= 10; k++) begin
         MD_start_ex     = (k == 3);
         Branch_taken_ex = (k == 5);
         cycle();
         chk("md_ovl_busy", s_busy, (k <= 8));
         chk("md_ovl_done", s_done, (k == 8));
         if (k == 5) chk("md_ovl_flush", s_fl, 1);
      end
      idle();

      // Reset mid-operation at cycle 14.
      reset_dut();
      repeat (9) cycle();
      MD_start_ex = 1'b1;
      MDRead_id   = 1'b1;
      cycle();
      MD_start_ex = 1'b0;
      for (int k = 1; k <= 3; k++) cycle();
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", MD_busy, 0);
      chk("rst_mid_done", MD_done, 0);
      chk("rst_mid_cnt", StallCnt, 0);
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("rst_mid_no_done", s_done, 0);
         chk("rst_mid_no_busy", s_busy, 0);
      end
      idle();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst             = ($urandom_range(0, 49) == 0);
         MemRead_ex      = 1'($urandom_range(0, 1));
         RegWriteAddr_ex = 5'($urandom_range(0, 3));
         RsAddr_id       = 5'($urandom_range(0, 3));
         RtAddr_id       = 5'($urandom_range(0, 3));
         Branch_taken_ex = ($urandom_range(0, 5) == 0);
         MD_start_ex     = ($urandom_range(0, 7) == 0);
         MDRead_id       = 1'($urandom_range(0, 1));
         MD_start_id     = ($urandom_range(0, 3) == 0);
         cycle();
      end
      rst = 1'b0;
      idle();

      // Saturation of StallCnt under a continuous load-use stall.
      reset_dut();
      MemRead_ex      = 1'b1;
      RegWriteAddr_ex = 5'd9;
      RtAddr_id       = 5'd9;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", StallCnt, 16'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_ffff", StallCnt, 16'hFFFF);
      repeat (4) @(posedge clk);
      #1;
      chk("sat_hold", StallCnt, 16'hFFFF);
      chk("sat_pc_low", PCWrite, 0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
